// File: rtl/int_div_pkg.sv
// rtl/int_div_pkg.sv - shared types and constants for the sequential integer divider
//
// Contents:
//   div_op_e      operation encoding, matches funct3[1:0] of DIV/DIVU/REM/REMU
//   div_state_e   divider FSM states
//   DIV_MAX_W     widest operand the constant helpers below cover
//   DIV_ONES_MAX  all-ones constant, sliced down to WIDTH by the user
//   div_min_val   most-negative two's-complement value for a given width
//   op_is_signed  / op_is_rem  decode helpers
package int_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } div_state_e;

  localparam int unsigned DIV_MAX_W = 64;
  localparam logic [DIV_MAX_W-1:0] DIV_ONES_MAX = '1;

  function automatic logic [DIV_MAX_W-1:0] div_min_val(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  // funct3[0] clear selects the signed variants
  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  // funct3[1] set selects the remainder
  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/int_div_step.sv
// rtl/int_div_step.sv - one combinational restoring-division iteration
//
// Ports:
//   rem_i  partial remainder before the step (always < dsr_i)
//   quo_i  quotient register; its MSB is the next dividend bit shifted in
//   dsr_i  divisor magnitude
//   rem_o  partial remainder after the step
//   quo_o  quotient register shifted left with the new quotient bit in the LSB
module int_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The shifted remainder needs one extra bit: rem_i < dsr_i <= 2^WIDTH-1.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;

  always_comb begin
    rem_sh    = {rem_i, quo_i[WIDTH-1]};
    no_borrow = (rem_sh >= {1'b0, dsr_i});
    // When no borrow occurs the true difference is below dsr_i, so the low
    // WIDTH bits of a modulo-2^WIDTH subtraction are exact.
    diff      = rem_sh[WIDTH-1:0] - dsr_i;
    rem_o     = no_borrow ? diff : rem_sh[WIDTH-1:0];
    quo_o     = {quo_i[WIDTH-2:0], no_borrow};
  end

endmodule

// File: rtl/int_div_seq.sv
// rtl/int_div_seq.sv - sequential restoring divider for RISC-V DIV/DIVU/REM/REMU
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             kills any operation in flight on the next edge
//   in_valid_i/in_ready_o, op_i, dividend_i, divisor_i, tag_i   request side
//   out_valid_o/out_ready_i, result_o, tag_o                    result side
//   busy_o              high whenever the FSM is not idle
// Build option: INT_DIV_EARLY_OUT_EN resolves divide-by-zero, signed MIN/-1
// and divisor > dividend at accept time, skipping CALC and FIXUP.
module int_div_seq
  import int_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef INT_DIV_EARLY_OUT_EN
  localparam logic [WIDTH-1:0]     ALL_ONES = DIV_ONES_MAX[WIDTH-1:0];
  localparam logic [DIV_MAX_W-1:0] MIN_FULL = div_min_val(WIDTH);
  localparam logic [WIDTH-1:0]     MIN_VAL  = MIN_FULL[WIDTH-1:0];
`endif

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             out_valid_q, out_valid_d;

  // Accept-time operand analysis
  div_op_e          op_in;
  logic             sgn_in, a_neg, b_neg, b_zero, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign op_in  = div_op_e'(op_i);
  assign sgn_in = op_is_signed(op_in);
  assign a_neg  = sgn_in & dividend_i[WIDTH-1];
  assign b_neg  = sgn_in & divisor_i[WIDTH-1];
  assign a_mag  = a_neg ? -dividend_i : dividend_i;
  assign b_mag  = b_neg ? -divisor_i : divisor_i;
  assign b_zero = (divisor_i == '0);
  assign accept = (state_q == S_IDLE) & in_valid_i & ~flush_i;

  int_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tag_d       = tag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = op_in;
          tag_d     = tag_i;
          rem_d     = '0;
          quo_d     = a_mag;
          dsr_d     = b_mag;
          cnt_d     = '0;
          // x/0 keeps the all-ones quotient magnitude regardless of signs
          quo_neg_d = (a_neg ^ b_neg) & ~b_zero;
          rem_neg_d = a_neg;
          state_d   = S_CALC;
`ifdef INT_DIV_EARLY_OUT_EN
          if (b_zero) begin
            result_d    = op_is_rem(op_in) ? dividend_i : ALL_ONES;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (sgn_in && dividend_i == MIN_VAL && divisor_i == ALL_ONES) begin
            result_d    = op_is_rem(op_in) ? '0 : MIN_VAL;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (b_mag > a_mag) begin
            result_d    = op_is_rem(op_in) ? dividend_i : '0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (op_is_rem(op_q)) begin
          result_d = rem_neg_q ? -rem_q : rem_q;
        end else begin
          result_d = quo_neg_q ? -quo_q : quo_q;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= OP_DIV;
      tag_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_int_div_seq.sv
// tb/tb_int_div_seq.sv - randomized self-checking bench for int_div_seq
module tb_int_div_seq;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [TW-1:0] tag_out;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int_div_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .dividend_i  (a),
    .divisor_i   (b),
    .tag_i       (tag_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out),
    .busy_o      (busy)
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // RISC-V M-extension results from plain 64-bit arithmetic
  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    longint r;
    case (o)
      2'b00:   r = (y == 0) ? -1 : sx / sy;
      2'b01:   r = (y == 0) ? -1 : ux / uy;
      2'b10:   r = (y == 0) ? sx : sx % sy;
      default: r = (y == 0) ? ux : ux % uy;
    endcase
    return r[W-1:0];
  endfunction

  function automatic bit ref_early(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    longint mx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
    longint my = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
    if (mx < 0) mx = -mx;
    if (my < 0) my = -my;
    return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) || (my > mx);
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [W-1:0] x,
                                     input logic [W-1:0] y);
`ifdef INT_DIV_EARLY_OUT_EN
    return ref_early(o, x, y) ? 1 : W + 2;
`else
    return (o == 2'b00 && ref_early(o, x, y)) ? W + 2 : W + 2;
`endif
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Drives one request and returns once the accept edge has passed
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [TW-1:0] t);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); a = 32'($urandom); b = 32'($urandom); tag_in = TW'($urandom);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold);
    logic [W-1:0]  exp_r = ref_result(o, x, y);
    logic [TW-1:0] t     = TW'($urandom);
    int            n     = 1;
    bit            stable = 1'b1;
    start_op(o, x, y, t);
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency op%0d %h/%h", o, x, y), 32'(n), 32'(exp_latency(o, x, y)));
    check($sformatf("result op%0d %h/%h", o, x, y), result, exp_r);
    check("tag", 32'(tag_out), 32'(t));
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== exp_r || tag_out !== t) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after", 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 32'({in_ready, out_valid, busy}), 32'b100);
    check("reset_result", result, '0);
    check("reset_tag", 32'(tag_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op(2'b10, 32'h1234_5678, 32'h0000_0000, 0);
    run_op(2'b00, 32'h0000_0005, 32'h0000_0000, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b01, 32'h0000_0003, 32'h0000_0007, 0);
    run_op(2'b11, 32'h0000_0003, 32'h0000_0007, 5);

    // Flush 10 edges after accept
    start_op(2'b00, 32'd100, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 32'({in_ready, busy, out_valid}), 32'b100);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush wins over a simultaneous request
    in_valid = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_valid", 32'({in_ready, busy}), 32'b10);

    // Asynchronous reset mid-CALC
    start_op(2'b00, 32'd1000, 32'd3, 5'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_calc", 32'({out_valid, busy, in_ready}), 32'b001);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a result is waiting
    start_op(2'b01, 32'd1000, 32'd3, 5'd17);
    repeat (W + 4) @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_done_flags", 32'({out_valid, busy}), 32'b00);
    check("rst_done_result", result, '0);
    check("rst_done_tag", 32'(tag_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      run_op(2'($urandom), rnd_operand(), rnd_operand(), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
